// File: rtl/puf_sample_sequencer.sv
// PUF readout sequencer: enables the PUF with a latched challenge, takes NUM_SAMPLES synchronized
// snapshots of the raw ID, and reports the per-bit majority vote plus a count of non-unanimous bits.
module puf_sample_sequencer #(
  parameter int ID_WIDTH      = 64,
  parameter int NUM_SAMPLES   = 7,
  parameter int SETTLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         challenge_i,
  input  logic [ID_WIDTH-1:0] puf_id_i,
  output logic                puf_en_o,
  output logic [31:0]         puf_challenge_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                id_valid_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic [6:0]          unstable_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_GAP    = 3'd3,
    ST_VOTE   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST   = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST      = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [3:0]  LAST_SAMPLE   = 4'(NUM_SAMPLES - 1);
  localparam logic [3:0]  NUM_SAMPLES_L = 4'(NUM_SAMPLES);
  localparam logic [3:0]  MAJ_THRESH    = 4'(NUM_SAMPLES / 2);

  function automatic logic majority_bit(input logic [3:0] cnt);
    return (cnt > MAJ_THRESH);
  endfunction

  function automatic logic unanimous_bit(input logic [3:0] cnt);
    return (cnt == 4'd0) || (cnt == NUM_SAMPLES_L);
  endfunction

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [15:0]                timer_r;
  logic [15:0]                timer_nxt_s;
  logic [3:0]                 sample_cnt_r;
  logic [ID_WIDTH-1:0][3:0]   bit_cnt_r;
  logic [ID_WIDTH-1:0]        sync_meta_r;
  logic [ID_WIDTH-1:0]        sync_r;
  logic [ID_WIDTH-1:0]        vote_s;
  logic [6:0]                 unstable_s;
  logic                       start_acc_s;
  logic                       active_nxt_s;

  logic                       puf_en_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       id_valid_r;
  logic [ID_WIDTH-1:0]        id_r;
  logic [31:0]                chal_r;
  logic [6:0]                 unstable_r;

  assign start_acc_s  = (state_r == ST_IDLE) && start_i;
  assign active_nxt_s = state_nxt_s inside {ST_SETTLE, ST_SAMPLE, ST_GAP, ST_VOTE};

  // Two-flop synchronizer for the PUF response, which is asynchronous to clk_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta_r <= {ID_WIDTH{1'b0}};
      sync_r      <= {ID_WIDTH{1'b0}};
    end else begin
      sync_meta_r <= puf_id_i;
      sync_r      <= sync_meta_r;
    end
  end

  // Next-state and phase-timer logic; abort returns to IDLE from any state except DONE.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = 16'd0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_nxt_s = ST_SETTLE;
        else         state_nxt_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (abort_i)                    state_nxt_s = ST_IDLE;
        else if (timer_r == SETTLE_LAST) state_nxt_s = ST_SAMPLE;
        else                            state_nxt_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (abort_i)                          state_nxt_s = ST_IDLE;
        else if (sample_cnt_r == LAST_SAMPLE) state_nxt_s = ST_VOTE;
        else if (GAP_CYCLES == 0)             state_nxt_s = ST_SAMPLE;
        else                                  state_nxt_s = ST_GAP;
      end
      ST_GAP: begin
        if (abort_i)                  state_nxt_s = ST_IDLE;
        else if (timer_r == GAP_LAST) state_nxt_s = ST_SAMPLE;
        else                          state_nxt_s = ST_GAP;
      end
      ST_VOTE: begin
        if (abort_i) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if ((state_nxt_s == state_r) && ((state_r == ST_SETTLE) || (state_r == ST_GAP))) begin
      timer_nxt_s = timer_r + 16'd1;
    end else begin
      timer_nxt_s = 16'd0;
    end
  end

  // Per-bit majority vote and count of bits that disagreed across samples.
  always_comb begin
    vote_s     = {ID_WIDTH{1'b0}};
    unstable_s = 7'd0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      vote_s[i] = majority_bit(bit_cnt_r[i]);
      if (!unanimous_bit(bit_cnt_r[i])) begin
        unstable_s = unstable_s + 7'd1;
      end else begin
        unstable_s = unstable_s;
      end
    end
  end

  // State register and phase timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      timer_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Sample accumulation: counters are cleared on an accepted start and bumped once per SAMPLE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= {(ID_WIDTH * 4){1'b0}};
    end else if (start_acc_s) begin
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= {(ID_WIDTH * 4){1'b0}};
    end else if (state_r == ST_SAMPLE) begin
      sample_cnt_r <= sample_cnt_r + 4'd1;
      for (int i = 0; i < ID_WIDTH; i++) begin
        bit_cnt_r[i] <= bit_cnt_r[i] + {3'b000, sync_r[i]};
      end
    end
  end

  // Registered outputs; the result is committed only when VOTE completes without abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      puf_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      id_valid_r <= 1'b0;
      id_r       <= {ID_WIDTH{1'b0}};
      chal_r     <= 32'd0;
      unstable_r <= 7'd0;
    end else begin
      puf_en_r <= active_nxt_s;
      busy_r   <= active_nxt_s;
      done_r   <= (state_nxt_s == ST_DONE);
      if (start_acc_s) begin
        chal_r     <= challenge_i;
        id_valid_r <= 1'b0;
      end else if (state_nxt_s == ST_DONE) begin
        id_valid_r <= 1'b1;
      end
      if ((state_r == ST_VOTE) && !abort_i) begin
        id_r       <= vote_s;
        unstable_r <= unstable_s;
      end
    end
  end

  assign puf_en_o        = puf_en_r;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign id_valid_o      = id_valid_r;
  assign id_o            = id_r;
  assign puf_challenge_o = chal_r;
  assign unstable_cnt_o  = unstable_r;

endmodule
